// File: rtl/cve2_pkg.sv
// Shared CSR numbering, CSR operation encoding and HPM event indices for the
// cve2 performance counter block.
package cve2_pkg;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'd0,
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_op_e;

   typedef enum logic [11:0] {
      CSR_MCOUNTINHIBIT = 12'h320,
      CSR_MHPMEVENT3    = 12'h323,
      CSR_MCYCLE        = 12'hB00,
      CSR_MINSTRET      = 12'hB02,
      CSR_MHPMCOUNTER3  = 12'hB03,
      CSR_MCYCLEH       = 12'hB80,
      CSR_MINSTRETH     = 12'hB82,
      CSR_MHPMCOUNTER3H = 12'hB83,
      CSR_CYCLE         = 12'hC00,
      CSR_INSTRET       = 12'hC02,
      CSR_CYCLEH        = 12'hC80,
      CSR_INSTRETH      = 12'hC82
   } csr_num_e;

   localparam int EVT_LOAD         = 0;
   localparam int EVT_STORE        = 1;
   localparam int EVT_BRANCH       = 2;
   localparam int EVT_BRANCH_TAKEN = 3;
   localparam int EVT_JUMP         = 4;
   localparam int EVT_COMP_INSTR   = 5;
   localparam int EVT_MUL_WAIT     = 6;
   localparam int EVT_DIV_WAIT     = 7;
   localparam int EVT_LOAD_WAIT    = 8;
   localparam int EVT_STORE_WAIT   = 9;
   localparam int HPM_EVENT_NUM    = 10;

   localparam int MHPM_COUNTER_NUM_MAX = 10;

endpackage

// File: rtl/cve2_counter.sv
// One 64-bit-addressable counter; bits at or above Width are held at zero.
// A CSR write to either word wins over the increment in the same cycle.
module cve2_counter #(
   parameter int Width = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        write_lo,
   input  logic        write_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);

   localparam logic [63:0] Mask = (Width >= 64) ? '1 : ((64'd1 << Width) - 64'd1);

   logic [63:0] cnt_q;
   logic [63:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (write_lo) begin
         cnt_d = {cnt_q[63:32], wdata};
      end else if (write_hi) begin
         cnt_d = {wdata, cnt_q[31:0]};
      end else if (inc) begin
         cnt_d = cnt_q + 64'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d & Mask;
      end
   end

   assign value = cnt_q;

endmodule

// File: rtl/cve2_perf_counters.sv
// Machine performance counters: mcycle, minstret, mhpmcounter3.., their event
// selectors and mcountinhibit, with a zero-latency CSR read/modify/write port.
module cve2_perf_counters
   import cve2_pkg::*;
#(
   parameter int MHPMCounterNum   = 10,
   parameter int MHPMCounterWidth = 40
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        csr_access_i,
   input  csr_op_e     csr_op_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   output logic [31:0] csr_rdata_o,
   output logic        csr_illegal_o,
   input  logic        instr_ret_i,
   input  logic [9:0]  event_i,
   input  logic        debug_mode_i
);

   // Slot index equals the low five address bits: 0 mcycle, 2 minstret, 3.. hpm.
   localparam int NumSlots = 3 + MHPM_COUNTER_NUM_MAX;
   localparam logic [31:0] InhibitMask =
      32'h5 | (((32'd1 << MHPMCounterNum) - 32'd1) << 3);

   logic [31:0] mcountinhibit_q;
   logic [9:0]  mhpmevent   [NumSlots];
   logic [63:0] cnt_value   [NumSlots];
   logic [4:0]  idx;
   logic        sel_inhibit, sel_event, sel_cnt_lo, sel_cnt_hi, sel_user;
   logic [31:0] old_val, new_val;
   logic        csr_write;

   assign idx         = csr_addr_i[4:0];
   assign sel_inhibit = csr_addr_i == CSR_MCOUNTINHIBIT;
   assign sel_event   = ((csr_addr_i & 12'hFE0) == CSR_MCOUNTINHIBIT) && (idx >= 5'd3);
   assign sel_cnt_lo  = ((csr_addr_i & 12'hFE0) == CSR_MCYCLE) && (idx != 5'd1);
   assign sel_cnt_hi  = ((csr_addr_i & 12'hFE0) == CSR_MCYCLEH) && (idx != 5'd1);
   assign sel_user    = (csr_addr_i == CSR_CYCLE) || (csr_addr_i == CSR_CYCLEH) ||
                        (csr_addr_i == CSR_INSTRET) || (csr_addr_i == CSR_INSTRETH);

   always_comb begin
      old_val       = '0;
      csr_rdata_o   = '0;
      csr_illegal_o = 1'b0;
      csr_write     = 1'b0;
      if (csr_access_i && !rst_i) begin
         if (sel_inhibit) begin
            old_val = mcountinhibit_q;
         end else if (sel_event) begin
            for (int k = 0; k < NumSlots; k++) begin
               if (idx == 5'(k)) old_val = {22'b0, mhpmevent[k]};
            end
         end else if (sel_cnt_lo || sel_cnt_hi) begin
            for (int k = 0; k < NumSlots; k++) begin
               if (idx == 5'(k)) old_val = sel_cnt_hi ? cnt_value[k][63:32] : cnt_value[k][31:0];
            end
         end else if (sel_user) begin
            // User-level aliases are read-only views of mcycle/minstret.
            if (csr_addr_i[1]) old_val = csr_addr_i[7] ? cnt_value[2][63:32] : cnt_value[2][31:0];
            else               old_val = csr_addr_i[7] ? cnt_value[0][63:32] : cnt_value[0][31:0];
            csr_illegal_o = csr_op_i != CSR_OP_READ;
         end else begin
            csr_illegal_o = 1'b1;
         end
         csr_rdata_o = old_val;
         csr_write   = !csr_illegal_o && (csr_op_i != CSR_OP_READ);
      end
   end

   always_comb begin
      case (csr_op_i)
         CSR_OP_WRITE: new_val = csr_wdata_i;
         CSR_OP_SET:   new_val = old_val | csr_wdata_i;
         CSR_OP_CLEAR: new_val = old_val & ~csr_wdata_i;
         default:      new_val = old_val;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcountinhibit_q <= '0;
      end else if (csr_write && sel_inhibit) begin
         mcountinhibit_q <= new_val & InhibitMask;
      end
   end

   for (genvar k = 0; k < NumSlots; k++) begin : g_slot
      if ((k >= 3) && (k < 3 + MHPMCounterNum)) begin : g_hpm
         logic [9:0] evt_q;
         logic       inc;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               evt_q <= '0;
            end else if (csr_write && sel_event && (idx == 5'(k))) begin
               evt_q <= new_val[9:0];
            end
         end

         // Any number of matching events still counts as a single increment.
         assign inc = (|(event_i & evt_q)) && !mcountinhibit_q[k] && !debug_mode_i;
         assign mhpmevent[k] = evt_q;

         cve2_counter #(.Width(MHPMCounterWidth)) u_counter (
            .clk      (clk_i),
            .rst      (rst_i),
            .inc      (inc),
            .write_lo (csr_write && sel_cnt_lo && (idx == 5'(k))),
            .write_hi (csr_write && sel_cnt_hi && (idx == 5'(k))),
            .wdata    (new_val),
            .value    (cnt_value[k])
         );
      end else if ((k == 0) || (k == 2)) begin : g_base
         logic inc;

         if (k == 0) begin : g_cycle
            assign inc = !mcountinhibit_q[0] && !debug_mode_i;
         end else begin : g_instret
            assign inc = instr_ret_i && !mcountinhibit_q[2] && !debug_mode_i;
         end
         assign mhpmevent[k] = '0;

         cve2_counter #(.Width(64)) u_counter (
            .clk      (clk_i),
            .rst      (rst_i),
            .inc      (inc),
            .write_lo (csr_write && sel_cnt_lo && (idx == 5'(k))),
            .write_hi (csr_write && sel_cnt_hi && (idx == 5'(k))),
            .wdata    (new_val),
            .value    (cnt_value[k])
         );
      end else begin : g_none
         assign mhpmevent[k] = '0;
         assign cnt_value[k] = '0;
      end
   end

endmodule

// File: tb/tb_cve2_perf_counters.sv
// Bench for cve2_perf_counters: directed scenarios plus random CSR traffic,
// all checked against a behavioural counter model.
module tb_cve2_perf_counters;
   import cve2_pkg::*;

   localparam int NUM = 10;
   localparam int W   = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        access = 1'b0;
   csr_op_e     op = CSR_OP_READ;
   logic [11:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        iret = 1'b0;
   logic [9:0]  ev = '0;
   logic        dbg = 1'b0;
   logic [31:0] rdata, rdata2;
   logic        ill, ill2;

   always #5 clk = ~clk;

   cve2_perf_counters #(.MHPMCounterNum(NUM), .MHPMCounterWidth(W)) dut (
      .clk_i(clk), .rst_i(rst), .csr_access_i(access), .csr_op_i(op),
      .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_rdata_o(rdata),
      .csr_illegal_o(ill), .instr_ret_i(iret), .event_i(ev), .debug_mode_i(dbg)
   );

   cve2_perf_counters #(.MHPMCounterNum(2), .MHPMCounterWidth(W)) dut2 (
      .clk_i(clk), .rst_i(rst), .csr_access_i(access), .csr_op_i(op),
      .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_rdata_o(rdata2),
      .csr_illegal_o(ill2), .instr_ret_i(iret), .event_i(ev), .debug_mode_i(dbg)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: architectural registers indexed by CSR number low bits.
   logic [63:0] m_cnt [0:12];
   logic [9:0]  m_evt [0:12];
   logic [31:0] m_inh;
   logic [31:0] s_rd, s_rd2;
   logic        s_ill, s_ill2;

   function automatic bit implemented(int n);
      return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NUM);
   endfunction

   function automatic logic [63:0] width_mask(int n);
      if (n < 3 || W >= 64) return '1;
      return (64'd1 << W) - 64'd1;
   endfunction

   function automatic void m_clear();
      for (int n = 0; n <= 12; n++) begin
         m_cnt[n] = '0;
         m_evt[n] = '0;
      end
      m_inh = '0;
   endfunction

   // kind: 0 no target, 1 mcountinhibit, 2 mhpmevent, 3 counter low, 4 counter high
   function automatic void m_eval(input logic [11:0] a, input csr_op_e o,
                                  output logic [31:0] rd, output logic il,
                                  output int kind, output int n);
      rd = '0; il = 1'b0; kind = 0; n = int'(a & 12'h01F);
      if (a == 12'h320) begin
         rd = m_inh; kind = 1;
      end else if (a >= 12'h323 && a <= 12'h33F) begin
         if (n < 3 + NUM) begin rd = {22'b0, m_evt[n]}; kind = 2; end
      end else if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) begin
         if (n == 1) il = 1'b1;
         else if (implemented(n)) begin
            if (a >= 12'hB80) begin rd = m_cnt[n][63:32]; kind = 4; end
            else begin rd = m_cnt[n][31:0]; kind = 3; end
         end
      end else if (a == 12'hC00 || a == 12'hC80 || a == 12'hC02 || a == 12'hC82) begin
         n = (a == 12'hC02 || a == 12'hC82) ? 2 : 0;
         rd = (a >= 12'hC80) ? m_cnt[n][63:32] : m_cnt[n][31:0];
         il = (o != CSR_OP_READ);
      end else begin
         il = 1'b1;
      end
   endfunction

   task automatic step(input logic a_acc, input csr_op_e a_op, input logic [11:0] a_addr,
                       input logic [31:0] a_wd, input logic a_iret, input logic [9:0] a_ev,
                       input logic a_dbg);
      logic [31:0] e_rd, nv;
      logic        e_ill;
      int          kind, n;
      logic [63:0] nxt [0:12];
      bit          inc;
      @(negedge clk);
      rst = 1'b0; access = a_acc; op = a_op; addr = a_addr; wdata = a_wd;
      iret = a_iret; ev = a_ev; dbg = a_dbg;
      #1;
      s_rd = rdata; s_ill = ill; s_rd2 = rdata2; s_ill2 = ill2;
      m_eval(a_addr, a_op, e_rd, e_ill, kind, n);
      if (!a_acc) begin e_rd = '0; e_ill = 1'b0; kind = 0; end
      check("rdata", s_rd, e_rd);
      check("illegal", {31'b0, s_ill}, {31'b0, e_ill});
      @(posedge clk);
      for (int k = 0; k <= 12; k++) begin
         nxt[k] = m_cnt[k];
         if (!implemented(k) || a_dbg || m_inh[k]) inc = 0;
         else if (k == 0) inc = 1;
         else if (k == 2) inc = a_iret;
         else inc = (a_ev & m_evt[k]) != 0;
         if (inc) nxt[k] = (m_cnt[k] + 64'd1) & width_mask(k);
      end
      if (a_acc && !e_ill && a_op != CSR_OP_READ && kind != 0) begin
         case (a_op)
            CSR_OP_WRITE: nv = a_wd;
            CSR_OP_SET:   nv = e_rd | a_wd;
            default:      nv = e_rd & ~a_wd;
         endcase
         case (kind)
            1: for (int b = 0; b < 32; b++)
                  m_inh[b] = (b == 0 || b == 2 || (b >= 3 && b < 3 + NUM)) ? nv[b] : 1'b0;
            2: m_evt[n] = nv[9:0];
            3: nxt[n] = {m_cnt[n][63:32], nv} & width_mask(n);
            default: nxt[n] = {nv, m_cnt[n][31:0]} & width_mask(n);
         endcase
      end
      for (int k = 0; k <= 12; k++) m_cnt[k] = nxt[k];
   endtask

   task automatic rd(input logic [11:0] a);
      step(1'b1, CSR_OP_READ, a, 32'h0, 1'b0, 10'h0, 1'b0);
   endtask

   task automatic wr(input csr_op_e o, input logic [11:0] a, input logic [31:0] d);
      step(1'b1, o, a, d, 1'b0, 10'h0, 1'b0);
   endtask

   task automatic idle(input int cycles, input logic [9:0] e);
      for (int i = 0; i < cycles; i++) step(1'b0, CSR_OP_READ, 12'h0, 32'h0, 1'b0, e, 1'b0);
   endtask

   // Reset arrives with an illegal write on the bus; outputs must stay quiet.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; access = 1'b1; op = CSR_OP_WRITE; addr = 12'h7FF; wdata = $urandom;
      #1;
      check("rst_rdata", rdata, 32'h0);
      check("rst_illegal", {31'b0, ill}, 32'h0);
      @(posedge clk);
      m_clear();
      access = 1'b0;
   endtask

   logic [11:0] addr_tab [22];

   initial begin
      addr_tab = '{12'h320, 12'h323, 12'h324, 12'h32C, 12'h32F, 12'hB00, 12'hB02,
                   12'hB03, 12'hB07, 12'hB0C, 12'hB10, 12'hB80, 12'hB82, 12'hB83,
                   12'hB8C, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'h7FF, 12'hB01, 12'h321};
      m_clear();
      do_reset();

      idle(100, 10'h0);
      rd(12'hB00); check("s1_mcycle", s_rd, 32'd100);
      rd(12'hB02); check("s1_minstret", s_rd, 32'd0);
      rd(12'hB03); check("s1_hpm3", s_rd, 32'd0);
      rd(12'hB0C); check("s1_hpm12", s_rd, 32'd0);

      wr(CSR_OP_WRITE, 12'hB00, 32'hFFFF_FFFF);
      wr(CSR_OP_WRITE, 12'hB80, 32'h0);
      idle(1, 10'h0);
      rd(12'hB00); check("s2_mcycle_wrap", s_rd, 32'h0);
      rd(12'hB00); check("s2_mcycle_next", s_rd, 32'h1);
      rd(12'hB80); check("s2_mcycleh", s_rd, 32'h1);

      wr(CSR_OP_WRITE, 12'hB02, 32'h5);
      step(1'b1, CSR_OP_WRITE, 12'hB02, 32'h10, 1'b1, 10'h0, 1'b0);
      rd(12'hB02); check("s3_minstret_prio", s_rd, 32'h10);

      wr(CSR_OP_WRITE, 12'h323, 32'h3);
      idle(4, 10'h003);
      rd(12'hB03); check("s4_hpm3", s_rd, 32'd4);
      wr(CSR_OP_SET, 12'h320, 32'h8);
      idle(3, 10'h003);
      rd(12'hB03); check("s4_hpm3_frozen", s_rd, 32'd4);
      rd(12'h320); check("s4_inhibit", s_rd, 32'h8);
      wr(CSR_OP_CLEAR, 12'h320, 32'h8);

      wr(CSR_OP_WRITE, 12'hC00, 32'h0); check("s5_cycle_wr_illegal", {31'b0, s_ill}, 32'h1);
      rd(12'h7FF);
      check("s5_unmapped_illegal", {31'b0, s_ill}, 32'h1);
      check("s5_unmapped_rdata", s_rd, 32'h0);
      step(1'b0, CSR_OP_READ, 12'hB00, 32'h0, 1'b0, 10'h0, 1'b0);
      check("s5_idle_rdata", s_rd, 32'h0);

      wr(CSR_OP_WRITE, 12'hB83, 32'hFFFF_FFFF);
      rd(12'hB83); check("s6_hpm3h_width", s_rd, 32'h0000_00FF);
      wr(CSR_OP_WRITE, 12'hB0C, 32'h1234);
      rd(12'hB0C);
      check("s6_hpm12_impl", s_rd, 32'h1234);
      check("s6_hpm12_absent_rdata", s_rd2, 32'h0);
      check("s6_hpm12_absent_illegal", {31'b0, s_ill2}, 32'h0);
      wr(CSR_OP_WRITE, 12'hFFF & 12'h320, 32'hFFFF_FFFF);
      rd(12'h320); check("s6_inhibit_mask", s_rd, 32'h0000_1FFD);
      wr(CSR_OP_WRITE, 12'h320, 32'h0);

      for (int i = 0; i < 1500; i++) begin
         logic [31:0] d;
         if (i == 750) do_reset();
         d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
         step($urandom_range(0, 3) != 0, csr_op_e'($urandom_range(0, 3)),
              addr_tab[$urandom_range(0, 21)], d, 1'($urandom_range(0, 1)),
              10'($urandom), $urandom_range(0, 9) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
